// File: rtl/sram_controller_if.sv
// Pipeline-side request bus between the MEM stage and the SRAM controller.
// The master is the pipeline; the slave is the controller.
interface sram_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, writeData,
    input  readData, ready
  );

  modport slave (
    input  rd_en, wr_en, address, writeData,
    output readData, ready
  );
endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two halfword accesses on a
// 16-bit asynchronous SRAM (low half first), holding ready low until done.
module sram_controller #(
  parameter int unsigned BASE_ADDR     = 1024,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  sram_controller_if.slave  bus,
  output logic [17:0]       SRAMaddress,
  output logic              SRAMWEn,
  inout  wire  [15:0]       SRAMdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT     = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] PRE_LAST_CNT = 4'(ACCESS_CYCLES - 2);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        wr_r;
  logic [15:0] idx_r;
  logic [31:0] wdata_r;
  logic [31:0] read_data_r;
  logic [15:0] bus_out_r;
  logic        drive_r;
  logic [17:0] sram_addr_r;
  logic        we_n_r;

  logic        req_s;
  logic        last_s;
  logic        pre_last_s;
  logic [31:0] eff_s;
  logic [15:0] idx_s;
  logic        unused_eff_s;

  assign req_s        = bus.rd_en | bus.wr_en;
  assign last_s       = (cnt_r == LAST_CNT);
  assign pre_last_s   = (cnt_r == PRE_LAST_CNT);
  // Addresses below BASE_ADDR wrap modulo 2^32; byte offset bits are dropped.
  assign eff_s        = bus.address - 32'(BASE_ADDR);
  assign idx_s        = eff_s[17:2];
  assign unused_eff_s = ^{eff_s[31:18], eff_s[1:0]};

  assign SRAMaddress  = sram_addr_r;
  assign SRAMWEn      = we_n_r;
  assign SRAMdata     = drive_r ? bus_out_r : 16'hzzzz;
  assign bus.readData = read_data_r;

  // Ready is combinational from the request in IDLE so an idle pipeline never stalls.
  always_comb begin
    bus.ready = 1'b0;
    case (state_r)
      IDLE:    bus.ready = ~req_s;
      DONE:    bus.ready = 1'b1;
      default: bus.ready = 1'b0;
    endcase
  end

  // Transaction sequencer; SRAM pins are set one edge ahead so they are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      wr_r        <= 1'b0;
      idx_r       <= 16'd0;
      wdata_r     <= 32'd0;
      read_data_r <= 32'd0;
      bus_out_r   <= 16'd0;
      drive_r     <= 1'b0;
      sram_addr_r <= 18'd0;
      we_n_r      <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            state_r     <= LOW;
            cnt_r       <= 4'd0;
            wr_r        <= bus.wr_en;
            idx_r       <= idx_s;
            wdata_r     <= bus.writeData;
            sram_addr_r <= {1'b0, idx_s, 1'b0};
            we_n_r      <= ~bus.wr_en;
            drive_r     <= bus.wr_en;
            bus_out_r   <= bus.writeData[15:0];
          end
        end
        LOW: begin
          if (last_s) begin
            state_r     <= HIGH;
            cnt_r       <= 4'd0;
            sram_addr_r <= {1'b0, idx_r, 1'b1};
            we_n_r      <= ~wr_r;
            bus_out_r   <= wdata_r[31:16];
            if (!wr_r) begin
              read_data_r[15:0] <= SRAMdata;
            end
          end else begin
            cnt_r  <= cnt_r + 4'd1;
            // WE rises one cycle before the phase ends so address/data hold past it.
            we_n_r <= pre_last_s | ~wr_r;
          end
        end
        HIGH: begin
          if (last_s) begin
            state_r <= DONE;
            cnt_r   <= 4'd0;
            we_n_r  <= 1'b1;
            drive_r <= 1'b0;
            if (!wr_r) begin
              read_data_r[31:16] <= SRAMdata;
            end
          end else begin
            cnt_r  <= cnt_r + 4'd1;
            we_n_r <= pre_last_s | ~wr_r;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          we_n_r  <= 1'b1;
          drive_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: a vector table of 32-bit transactions
// checked cycle by cycle, plus idle, done-hold and mid-transaction reset sequences.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        sram_oe;
  logic [17:0] sram_address;
  logic        sram_wen;
  wire  [15:0] sram_data;
  logic [15:0] mem [0:262143];

  int n_checks;
  int n_fail;

  sram_controller_if bus_if ();

  sram_controller #(
    .BASE_ADDR     (1024),
    .ACCESS_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .SRAMaddress (sram_address),
    .SRAMWEn     (sram_wen),
    .SRAMdata    (sram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM model: drives the bus when output-enabled, writes on WE rising.
  assign sram_data = sram_oe ? mem[sram_address] : 16'hzzzz;

  always @(posedge sram_wen) begin
    if (!rst) begin
      mem[sram_address] <= sram_data;
    end
  end

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] lo;
    logic [17:0] hi;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies one transaction at posedge+1 and returns at posedge+1 after DONE.
  task automatic run_txn(input int idx, input vec_t v);
    bus_if.wr_en     = v.wr;
    bus_if.rd_en     = v.rd;
    bus_if.address   = v.addr;
    bus_if.writeData = v.wdata;
    sram_oe          = ~v.wr;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("v%0d_c%0d_ready", idx, c), {31'd0, bus_if.ready}, (c < 5) ? 32'd0 : 32'd1);
      if (c >= 1 && c <= 4) begin
        check($sformatf("v%0d_c%0d_addr", idx, c), {14'd0, sram_address},
              (c < 3) ? {14'd0, v.lo} : {14'd0, v.hi});
        check($sformatf("v%0d_c%0d_wen", idx, c), {31'd0, sram_wen},
              (c == 1 || c == 3) ? {31'd0, ~v.wr} : 32'd1);
        if (v.wr) begin
          check($sformatf("v%0d_c%0d_data", idx, c), {16'd0, sram_data},
                (c < 3) ? {16'd0, v.wdata[15:0]} : {16'd0, v.wdata[31:16]});
        end
      end
      if (c == 5) begin
        check($sformatf("v%0d_readData", idx), bus_if.readData, v.exp_rd);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 262144; i++) begin
      mem[i] = 16'(i) ^ 16'h5A5A;
    end

    vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'h00000, 18'h00001, 32'h00000000};
    vecs[1] = '{1'b0, 1'b1, 32'd1024, 32'h00000000, 18'h00000, 18'h00001, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 32'd1028, 32'h12345678, 18'h00002, 18'h00003, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 32'd1028, 32'h00000000, 18'h00002, 18'h00003, 32'h12345678};
    vecs[4] = '{1'b1, 1'b0, 32'd1020, 32'hCAFEF00D, 18'h1FFFE, 18'h1FFFF, 32'h12345678};
    vecs[5] = '{1'b0, 1'b1, 32'd1020, 32'h00000000, 18'h1FFFE, 18'h1FFFF, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 1'b0, 32'd1032, 32'h0000FFFF, 18'h00004, 18'h00005, 32'hCAFEF00D};
    vecs[7] = '{1'b0, 1'b1, 32'd1032, 32'h00000000, 18'h00004, 18'h00005, 32'h0000FFFF};

    rst              = 1'b1;
    sram_oe          = 1'b1;
    bus_if.rd_en     = 1'b0;
    bus_if.wr_en     = 1'b0;
    bus_if.address   = 32'd0;
    bus_if.writeData = 32'd0;

    // Reset values and ten idle cycles.
    @(negedge clk);
    check("rst_wen", {31'd0, sram_wen}, 32'd1);
    check("rst_addr", {14'd0, sram_address}, 32'd0);
    check("rst_readData", bus_if.readData, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d_ready", i), {31'd0, bus_if.ready}, 32'd1);
      check($sformatf("idle%0d_wen", i), {31'd0, sram_wen}, 32'd1);
      check($sformatf("idle%0d_readData", i), bus_if.readData, 32'd0);
      check($sformatf("idle%0d_bus", i), {16'd0, sram_data}, 32'h00005A5A);
    end

    // Back-to-back table: each vector starts the cycle after the previous DONE.
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      run_txn(i, vecs[i]);
    end

    // DONE must have returned to IDLE rather than restarting on the held read.
    bus_if.rd_en = 1'b0;
    bus_if.wr_en = 1'b0;
    @(negedge clk);
    check("after_done_ready", {31'd0, bus_if.ready}, 32'd1);
    check("after_done_wen", {31'd0, sram_wen}, 32'd1);

    // Reset during the HIGH phase of a write to 1036 (halfwords 6/7).
    @(posedge clk);
    #1;
    bus_if.wr_en     = 1'b1;
    bus_if.address   = 32'd1036;
    bus_if.writeData = 32'h11112222;
    sram_oe          = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_high_addr", {14'd0, sram_address}, 32'd7);
    check("mid_high_wen", {31'd0, sram_wen}, 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check("abort_wen", {31'd0, sram_wen}, 32'd1);
    check("abort_addr", {14'd0, sram_address}, 32'd0);
    check("abort_readData", bus_if.readData, 32'd0);
    check("abort_ready_req_held", {31'd0, bus_if.ready}, 32'd0);
    bus_if.wr_en = 1'b0;
    sram_oe      = 1'b1;
    #1;
    check("abort_ready_idle", {31'd0, bus_if.ready}, 32'd1);
    check("abort_bus_released", {16'd0, sram_data}, 32'h0000BEEF);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d_ready", i), {31'd0, bus_if.ready}, 32'd1);
      check($sformatf("post_rst%0d_wen", i), {31'd0, sram_wen}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Bridges the 32-bit MEM stage to the board's 16-bit asynchronous SRAM, one level downstream of the memory-stage access logic.
- Each 32-bit load or store becomes two sequenced halfword accesses: low half first, then high half.
- Deasserts ready for the whole transaction. The pipeline derives its global stall (SRAM_NOT_READY / superStall) as ~ready.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM halfword 0.
- ACCESS_CYCLES, 2: cycles per halfword phase; legal range 2..15.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_en  input  1  load request, held stable by the stalled pipeline until ready=1.
- wr_en  input  1  store request, same holding rule; has priority over rd_en.
- address  input  32  byte address of the access.
- writeData  input  32  store data.
- readData  output  32  load result.
- ready  output  1  1 = no transaction in progress or transaction completing this cycle.
- SRAMaddress  output  18  SRAM halfword address.
- SRAMWEn  output  1  SRAM write enable, active-low.
- SRAMdata  inout  16  SRAM data bus; driven only during write phases, else high-Z.

Behaviour:
- Reset, asynchronous and may occur at any point including mid-transaction:
  - state=IDLE, phase counter=0.
  - readData=0, latched address/data=0.
  - SRAMWEn=1, SRAMdata high-Z, SRAMaddress=0.
  - ready=1 once no request is present.
  - An aborted store leaves SRAM contents undefined at that address; no retry is performed.
- Address mapping:
  - eff = address - BASE_ADDR, computed modulo 2^32; addresses below BASE_ADDR wrap silently.
  - idx = eff[17:2]; eff[1:0] is ignored (word-aligned only).
  - Low halfword at SRAMaddress = {1'b0, idx, 1'b0}; high halfword at {1'b0, idx, 1'b1}.
- States: IDLE, LOW, HIGH, DONE.
  - IDLE:
    - ready = ~(rd_en | wr_en), combinational.
    - On a request: latch address, writeData and op (wr_en ? write : read), clear the counter, go to LOW.
  - LOW:
    - SRAMaddress = low address.
    - Runs ACCESS_CYCLES cycles, counter 0..ACCESS_CYCLES-1, then goes to HIGH with the counter cleared.
  - HIGH:
    - SRAMaddress = high address.
    - Runs the same counting as LOW, then goes to DONE.
  - DONE:
    - ready=1; readData holds the valid assembled word.
    - Always returns to IDLE.
    - Requests still asserted during DONE are the completed access and must not restart a transaction.
- Write phases:
  - SRAMdata = writeData[15:0] in LOW and writeData[31:16] in HIGH, for every cycle of the phase.
  - SRAMWEn=0 for counter < ACCESS_CYCLES-1 and 1 on the last cycle of each phase, so address and data hold past the WE rising edge.
- Read phases:
  - SRAMWEn=1 and SRAMdata high-Z.
  - On the last cycle of LOW, capture SRAMdata into readData[15:0].
  - On the last cycle of HIGH, capture SRAMdata into readData[31:16].
- readData holds its value until the next read overwrites it; writes do not alter it.
- Latency:
  - The request cycle plus 2*ACCESS_CYCLES cycles have ready=0; the DONE cycle follows.
  - With default ACCESS_CYCLES=2, ready is low for 5 cycles and high on the 6th.
- rd_en and wr_en both asserted: the access is treated as a write.
- Request inputs changing mid-transaction are ignored; the latched values are used.
- ready is never 0 while in IDLE with no request, so the pipeline never stalls when idle.

Test Plan:
- Reset then idle, no requests for 10 cycles -> ready=1, SRAMWEn=1, SRAMdata high-Z throughout, readData=0.
- Write, address=1024, writeData=0xDEADBEEF -> ready low for 5 cycles; LOW phase: SRAMaddress=0, SRAMdata=0xBEEF, SRAMWEn 0 then 1; HIGH phase: SRAMaddress=1, SRAMdata=0xDEAD, SRAMWEn 0 then 1; DONE: ready=1.
- Read back, rd_en at address=1024 with the SRAM model holding the previous write -> readData=0xDEADBEEF on the DONE cycle; SRAMWEn stays 1; the held rd_en during DONE does not start a new access.
- Address wrap and priority, address=1028 with wr_en=rd_en=1 and writeData=0x12345678 -> treated as write to SRAMaddress 2 and 3; address=1020 maps to idx 0xFFFF, i.e. SRAMaddress 0x1FFFE and 0x1FFFF.
- Reset mid-operation, rst pulsed during the HIGH phase of a write -> immediately state IDLE, SRAMWEn=1, bus high-Z, readData=0; with requests deasserted, ready=1 after reset.
- Back-to-back: write 0x0000FFFF at 1032, then a read of 1032 presented the cycle after DONE -> second transaction starts from IDLE, returns 0x0000FFFF, ready pattern 5 low / 1 high per access.
